// File: rtl/mandelbrot_frame_sequencer.sv
// mandelbrot_frame_sequencer
//   Steps the Mandelbrot engine across a cols x rows pixel grid. For each pixel it
//   drives the engine cr/ci, pulses eng_run, waits for the engine's busy flag to fall,
//   and then hands the iteration count to the framebuffer over a valid/ready link.
//   cr advances by step along a row. ci decreases by step per row, so the top row
//   is produced first.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   start, abort        frame start (IDLE only) / synchronous frame abort
//   cfg_cr0/ci0/step    origin and per-pixel increment, two's complement
//   cfg_cols/rows       frame dimensions, latched at start
//   eng_run/cr/ci       engine launch pulse and pixel coordinates
//   eng_running/ctr     engine busy flag and iteration count
//   frame_start         one-cycle pulse at the beginning of a frame
//   pix_valid/ready     pixel handshake, with pix_data and pix_last
//   busy, done          sequencer active / one-cycle frame-complete pulse
module mandelbrot_frame_sequencer #(
    parameter int BITWIDTH = 11,
    parameter int CTRWIDTH = 7,
    parameter int DIMWIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [BITWIDTH-1:0] cfg_cr0,
    input  logic [BITWIDTH-1:0] cfg_ci0,
    input  logic [BITWIDTH-1:0] cfg_step,
    input  logic [DIMWIDTH-1:0] cfg_cols,
    input  logic [DIMWIDTH-1:0] cfg_rows,
    output logic                eng_run,
    output logic [BITWIDTH-1:0] eng_cr,
    output logic [BITWIDTH-1:0] eng_ci,
    input  logic                eng_running,
    input  logic [CTRWIDTH-1:0] eng_ctr,
    output logic                frame_start,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [CTRWIDTH-1:0] pix_data,
    output logic                pix_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [DIMWIDTH-1:0] col_q, col_d;
    logic [DIMWIDTH-1:0] row_q, row_d;
    logic [DIMWIDTH-1:0] cols_q, cols_d;
    logic [DIMWIDTH-1:0] rows_q, rows_d;
    logic [BITWIDTH-1:0] cr0_q, cr0_d;
    logic [BITWIDTH-1:0] step_q, step_d;
    logic [BITWIDTH-1:0] eng_cr_q, eng_cr_d;
    logic [BITWIDTH-1:0] eng_ci_q, eng_ci_d;
    logic                seen_hi_q, seen_hi_d;
    logic                running_q, running_d;
    logic [CTRWIDTH-1:0] pix_data_q, pix_data_d;
    logic                frame_start_q, frame_start_d;
    logic                done_q, done_d;

    logic                last_col;
    logic                last_row;

    assign last_col = (col_q == cols_q - DIMWIDTH'(1));
    assign last_row = (row_q == rows_q - DIMWIDTH'(1));

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        cols_d        = cols_q;
        rows_d        = rows_q;
        cr0_d         = cr0_q;
        step_d        = step_q;
        eng_cr_d      = eng_cr_q;
        eng_ci_d      = eng_ci_q;
        seen_hi_d     = seen_hi_q;
        running_d     = eng_running;
        pix_data_d    = pix_data_q;
        frame_start_d = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((cfg_cols != '0) && (cfg_rows != '0)) begin
                        cols_d        = cfg_cols;
                        rows_d        = cfg_rows;
                        cr0_d         = cfg_cr0;
                        step_d        = cfg_step;
                        col_d         = '0;
                        row_d         = '0;
                        eng_cr_d      = cfg_cr0;
                        eng_ci_d      = cfg_ci0;
                        frame_start_d = 1'b1;
                        state_d       = S_LAUNCH;
                    end else begin
                        // Empty frame: report completion without touching the engine.
                        done_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                seen_hi_d = 1'b0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (eng_running) begin
                    seen_hi_d = 1'b1;
                end
                // Falling edge of eng_running, qualified by having seen it high
                // for this pixel so a stale low-to-low never completes early.
                if (seen_hi_q && running_q && !eng_running) begin
                    pix_data_d = eng_ctr;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                if (pix_ready) begin
                    if (last_col && last_row) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (!last_col) begin
                        col_d    = col_q + DIMWIDTH'(1);
                        eng_cr_d = eng_cr_q + step_q;
                        state_d  = S_LAUNCH;
                    end else begin
                        col_d    = '0;
                        row_d    = row_q + DIMWIDTH'(1);
                        eng_cr_d = cr0_q;
                        eng_ci_d = eng_ci_q - step_q;
                        state_d  = S_LAUNCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a handshake in the same cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            cols_q        <= '0;
            rows_q        <= '0;
            cr0_q         <= '0;
            step_q        <= '0;
            eng_cr_q      <= '0;
            eng_ci_q      <= '0;
            seen_hi_q     <= 1'b0;
            running_q     <= 1'b0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            cols_q        <= cols_d;
            rows_q        <= rows_d;
            cr0_q         <= cr0_d;
            step_q        <= step_d;
            eng_cr_q      <= eng_cr_d;
            eng_ci_q      <= eng_ci_d;
            seen_hi_q     <= seen_hi_d;
            running_q     <= running_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

    assign eng_run     = (state_q == S_LAUNCH);
    assign pix_valid   = (state_q == S_EMIT);
    assign pix_last    = (state_q == S_EMIT) && last_col && last_row;
    assign busy        = (state_q != S_IDLE);
    assign eng_cr      = eng_cr_q;
    assign eng_ci      = eng_ci_q;
    assign pix_data    = pix_data_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mandelbrot_frame_sequencer.sv
// Testbench for mandelbrot_frame_sequencer: a behavioural engine, a ready driver,
// a scoreboard of expected launches and pixels, and a monitor that checks them.
module tb_mandelbrot_frame_sequencer;

    localparam int BW = 11;
    localparam int CW = 7;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [BW-1:0] cfg_cr0, cfg_ci0, cfg_step;
    logic [DW-1:0] cfg_cols, cfg_rows;
    logic          eng_run, eng_running;
    logic [BW-1:0] eng_cr, eng_ci;
    logic [CW-1:0] eng_ctr, pix_data;
    logic          frame_start, pix_valid, pix_ready, pix_last, busy, done;

    mandelbrot_frame_sequencer #(.BITWIDTH(BW), .CTRWIDTH(CW), .DIMWIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_cr0(cfg_cr0), .cfg_ci0(cfg_ci0), .cfg_step(cfg_step),
        .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
        .eng_run(eng_run), .eng_cr(eng_cr), .eng_ci(eng_ci),
        .eng_running(eng_running), .eng_ctr(eng_ctr),
        .frame_start(frame_start), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int cr; int ci; } launch_t;
    typedef struct { int data; int last; } pix_t;

    launch_t launch_q[$];
    pix_t    pix_q[$];

    int checks = 0, errors = 0;
    int run_count = 0, fs_count = 0, done_count = 0, hs_count = 0, stall_cycles = 0;
    int run_b, fs_b, done_b, stall_b;
    int hs_base = 0, stall_at = -1, stall_len = 0;
    int ready_mode = 0;   // 0 always ready, 1 random, 2 stall one pixel, 3 never ready
    int lat_mode = 5;     // 0 random engine latency, else fixed

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Engine result as a plain function of the pixel coordinates.
    function automatic int ctr_of(input int cr, input int ci);
        return (cr * 3 + ci * 5 + 11) % 128;
    endfunction

    function automatic int wrap11(input int v);
        return ((v % 2048) + 2048) % 2048;
    endfunction

    // Reference model: raster order, top row first, coordinates modulo 2^11.
    task automatic push_frame(input int cr0, input int ci0, input int step,
                              input int cols, input int rows);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                launch_t l;
                pix_t    p;
                l.cr   = wrap11(cr0 + c * step);
                l.ci   = wrap11(ci0 - r * step);
                p.data = ctr_of(l.cr, l.ci);
                p.last = (r == rows - 1 && c == cols - 1) ? 1 : 0;
                launch_q.push_back(l);
                pix_q.push_back(p);
            end
        end
    endtask

    // Behavioural engine: busy for N cycles after a run pulse; the count is only
    // meaningful once running has fallen, garbage while busy.
    initial begin
        int rem;
        int lcr, lci;
        rem = 0; lcr = 0; lci = 0;
        eng_running = 1'b0;
        eng_ctr     = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                rem = 0;
                eng_running <= 1'b0;
            end else if (eng_run) begin
                lcr = int'(eng_cr);
                lci = int'(eng_ci);
                rem = (lat_mode > 0) ? lat_mode : int'($urandom_range(1, 6));
                eng_running <= 1'b1;
                eng_ctr     <= CW'($urandom);
            end else if (rem > 1) begin
                rem = rem - 1;
                eng_ctr <= CW'($urandom);
            end else if (rem == 1) begin
                rem = 0;
                eng_running <= 1'b0;
                eng_ctr     <= CW'(ctr_of(lcr, lci));
            end
        end
    end

    // Ready driver.
    initial begin
        int st;
        st = 0;
        pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hs_count - hs_base != stall_at) st = 0;
            case (ready_mode)
                0: pix_ready = 1'b1;
                1: pix_ready = ($urandom % 3) != 0;
                2: begin
                    if (pix_valid && (hs_count - hs_base == stall_at) && st < stall_len) begin
                        pix_ready = 1'b0;
                        st++;
                    end else begin
                        pix_ready = 1'b1;
                    end
                end
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard checker.
    initial begin
        bit      pv, pr, pa, prun;
        int      pd, pl;
        launch_t l;
        pix_t    p;
        pv = 0; pr = 0; pa = 0; prun = 0; pd = 0; pl = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 0; pr = 0; pa = 0; prun = 0;
            end else begin
                if (eng_run) begin
                    run_count++;
                    chk(!prun, "run_width", 2, 1);
                    chk(!pix_valid, "run_while_valid", int'(pix_valid), 0);
                    if (launch_q.size() == 0) begin
                        chk(1'b0, "unexpected_run", run_count, 0);
                    end else begin
                        l = launch_q.pop_front();
                        chk(int'(eng_cr) == l.cr, "eng_cr", int'(eng_cr), l.cr);
                        chk(int'(eng_ci) == l.ci, "eng_ci", int'(eng_ci), l.ci);
                    end
                end
                if (frame_start) begin
                    fs_count++;
                    chk(eng_run, "frame_start_timing", int'(eng_run), 1);
                end
                if (done) begin
                    done_count++;
                    chk(!busy, "done_while_busy", int'(busy), 0);
                end
                if (pix_last) chk(pix_valid, "last_without_valid", int'(pix_valid), 1);
                if (pv && !pr && !pa) begin
                    chk(pix_valid, "valid_hold", int'(pix_valid), 1);
                    chk(int'(pix_data) == pd, "data_hold", int'(pix_data), pd);
                    chk(int'(pix_last) == pl, "last_hold", int'(pix_last), pl);
                end
                if (pix_valid && !pix_ready) stall_cycles++;
                if (pix_valid && pix_ready && !abort) begin
                    hs_count++;
                    if (pix_q.size() == 0) begin
                        chk(1'b0, "unexpected_pixel", int'(pix_data), -1);
                    end else begin
                        p = pix_q.pop_front();
                        chk(int'(pix_data) == p.data, "pix_data", int'(pix_data), p.data);
                        chk(int'(pix_last) == p.last, "pix_last", int'(pix_last), p.last);
                    end
                end
                pv = pix_valid; pr = pix_ready; pa = abort;
                pd = int'(pix_data); pl = int'(pix_last); prun = eng_run;
            end
        end
    end

    task automatic snap();
        run_b = run_count; fs_b = fs_count; done_b = done_count; stall_b = stall_cycles;
        hs_base = hs_count;
    endtask

    task automatic start_frame(input int cr0, input int ci0, input int step,
                               input int cols, input int rows);
        @(posedge clk); #1;
        cfg_cr0 = BW'(cr0); cfg_ci0 = BW'(ci0); cfg_step = BW'(step);
        cfg_cols = DW'(cols); cfg_rows = DW'(rows);
        start = 1'b1;
        if (cols != 0 && rows != 0) push_frame(cr0, ci0, step, cols, rows);
        @(posedge clk); #1;
        start = 1'b0;
        // Configuration changes after the latch must not matter.
        cfg_cr0 = BW'($urandom); cfg_ci0 = BW'($urandom); cfg_step = BW'($urandom);
        cfg_cols = DW'($urandom); cfg_rows = DW'($urandom);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (done_count > done_b) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic frame_checks(input int cols, input int rows);
        bit ok;
        wait_done(ok);
        chk(ok, "done_timeout", int'(ok), 1);
        repeat (2) @(posedge clk);
        #1;
        chk(fs_count - fs_b == 1, "frame_start_count", fs_count - fs_b, 1);
        chk(done_count - done_b == 1, "done_count", done_count - done_b, 1);
        chk(run_count - run_b == cols * rows, "run_count", run_count - run_b, cols * rows);
        chk(pix_q.size() == 0, "pixels_left", pix_q.size(), 0);
        chk(launch_q.size() == 0, "launches_left", launch_q.size(), 0);
        chk(!busy, "idle_after_frame", int'(busy), 0);
    endtask

    task automatic run_frame(input int cr0, input int ci0, input int step,
                             input int cols, input int rows);
        snap();
        start_frame(cr0, ci0, step, cols, rows);
        frame_checks(cols, rows);
    endtask

    task automatic check_all_zero(input string tag);
        chk(!eng_run,     {tag, "_eng_run"},     int'(eng_run), 0);
        chk(eng_cr == '0, {tag, "_eng_cr"},      int'(eng_cr), 0);
        chk(eng_ci == '0, {tag, "_eng_ci"},      int'(eng_ci), 0);
        chk(!frame_start, {tag, "_frame_start"}, int'(frame_start), 0);
        chk(!pix_valid,   {tag, "_pix_valid"},   int'(pix_valid), 0);
        chk(pix_data == '0, {tag, "_pix_data"},  int'(pix_data), 0);
        chk(!pix_last,    {tag, "_pix_last"},    int'(pix_last), 0);
        chk(!busy,        {tag, "_busy"},        int'(busy), 0);
        chk(!done,        {tag, "_done"},        int'(done), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got %0t expected below 5ms", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_cr0 = '0; cfg_ci0 = '0; cfg_step = '0; cfg_cols = '0; cfg_rows = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Directed frame, ready always high, 5-cycle engine; start while busy ignored.
        lat_mode = 5; ready_mode = 0;
        snap();
        start_frame(1536, 256, 16, 3, 2);  // cr0 = -512
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (run_count - run_b >= 2) begin ok = 1'b1; break; end
        end
        chk(ok, "mid_frame_timeout", int'(ok), 1);
        cfg_cols = 8'd7; cfg_rows = 8'd5; cfg_cr0 = 11'd3; cfg_step = 11'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        frame_checks(3, 2);

        // Ready held low for 10 cycles on the second pixel.
        ready_mode = 2; stall_at = 1; stall_len = 10;
        run_frame(1536, 256, 16, 3, 2);
        chk(stall_cycles - stall_b == 10, "stall_cycles", stall_cycles - stall_b, 10);
        ready_mode = 0; stall_at = -1;

        // Abort while waiting on the fourth pixel.
        snap();
        start_frame(1536, 256, 16, 3, 2);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (run_count - run_b >= 4) begin ok = 1'b1; break; end
        end
        chk(ok, "abort_wait_timeout", int'(ok), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk(!busy, "abort_busy", int'(busy), 0);
        chk(!pix_valid, "abort_valid", int'(pix_valid), 0);
        chk(!eng_run, "abort_run", int'(eng_run), 0);
        repeat (12) @(posedge clk);
        #1;
        chk(done_count == done_b, "abort_no_done", done_count - done_b, 0);
        chk(run_count - run_b == 4, "abort_runs", run_count - run_b, 4);
        chk(hs_count - hs_base == 3, "abort_pixels", hs_count - hs_base, 3);
        launch_q.delete();
        pix_q.delete();
        run_frame(1536, 256, 16, 3, 2);

        // Empty frames: done only.
        snap();
        start_frame(100, 100, 4, 0, 2);
        repeat (5) @(posedge clk);
        #1;
        chk(done_count - done_b == 1, "zero_cols_done", done_count - done_b, 1);
        chk(fs_count == fs_b, "zero_cols_fs", fs_count - fs_b, 0);
        chk(run_count == run_b, "zero_cols_run", run_count - run_b, 0);
        chk(!busy, "zero_cols_busy", int'(busy), 0);
        snap();
        start_frame(100, 100, 4, 3, 0);
        repeat (5) @(posedge clk);
        #1;
        chk(done_count - done_b == 1, "zero_rows_done", done_count - done_b, 1);
        chk(fs_count == fs_b, "zero_rows_fs", fs_count - fs_b, 0);
        chk(run_count == run_b, "zero_rows_run", run_count - run_b, 0);

        // Coordinate wrap: 1020 + 8 -> -1020.
        run_frame(1020, 0, 8, 2, 1);
        // Row step wrap on ci: -1020 - 8 -> 1020.
        run_frame(5, 1028, 8, 1, 2);

        // Randomised frames with random latency and ready.
        lat_mode = 0; ready_mode = 1;
        for (int f = 0; f < 10; f++) begin
            run_frame(int'($urandom % 2048), int'($urandom % 2048), int'($urandom % 2048),
                      int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
        end

        // Reset while a pixel is waiting in EMIT.
        lat_mode = 3; ready_mode = 3;
        snap();
        start_frame(200, 300, 12, 2, 2);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (pix_valid) begin ok = 1'b1; break; end
        end
        chk(ok, "emit_wait_timeout", int'(ok), 1);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        launch_q.delete();
        pix_q.delete();
        ready_mode = 0;
        snap();
        repeat (10) @(posedge clk);
        #1;
        chk(run_count == run_b, "no_repulse", run_count - run_b, 0);
        chk(!busy, "midreset_idle", int'(busy), 0);
        run_frame(1536, 256, 16, 3, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
